ifetch_queue: RTL and testbench



---
 rtl/ifetch_queue_if.sv | 38 +++
 rtl/ifetch_queue.sv | 111 +++++++++++
 tb/tb_ifetch_queue.sv | 365 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ifetch_queue_if.sv
// Fetch-side bus of the instruction prefetch queue: redirect request,
// instruction handshake toward the fetch stage and the instruction SRAM port.
// The master modport is the queue; the slave modport is its environment.
interface ifetch_queue_if;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst_data;
   logic [31:0] inst_pc;
   logic        isram_en;
   logic [13:0] isram_addr;
   logic [31:0] isram_dataout;

   modport master (
      input  redirect_valid,
      input  redirect_pc,
      input  inst_ready,
      input  isram_dataout,
      output inst_valid,
      output inst_data,
      output inst_pc,
      output isram_en,
      output isram_addr
   );

   modport slave (
      output redirect_valid,
      output redirect_pc,
      output inst_ready,
      output isram_dataout,
      input  inst_valid,
      input  inst_data,
      input  inst_pc,
      input  isram_en,
      input  isram_addr
   );
endinterface

// File: rtl/ifetch_queue.sv
// Instruction prefetch queue. Issues sequential word reads to a one-cycle
// latency instruction SRAM, buffers returned words with their byte address in
// a small FIFO and hands them to the fetch stage over valid/ready. A redirect
// flushes both the buffered entries and the read still in flight.
//
// Stage _p0 is the SRAM request (fetch_pc drives the address); stage _p1 is
// the returning read, tracked by vld_p1/pc_p1 and written into the FIFO.
// Issue is credit based: buffered entries plus the in-flight read never
// exceed DEPTH, so a returning word always has a free slot.
module ifetch_queue #(
   parameter int unsigned DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic           clk,
   input  logic           rst,
   ifetch_queue_if.master bus
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int NW = AW + 1;
   localparam int CW = AW + 2;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   // Byte address forced onto a word boundary.
   function automatic logic [31:0] align_word(input logic [31:0] pc);
      return {pc[31:2], 2'b00};
   endfunction

   // Next sequential word address; wraps modulo 2^32.
   function automatic logic [31:0] next_word(input logic [31:0] pc);
      return pc + 32'd4;
   endfunction

   // Request stage
   logic [31:0]   fetch_pc;
   logic          issue;

   // Response stage
   logic          vld_p1;
   logic [31:0]   pc_p1;

   // FIFO storage and bookkeeping
   logic [31:0]   data_mem [DEPTH];
   logic [31:0]   pc_mem   [DEPTH];
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic [NW-1:0] count;

   logic          head_vld;
   logic          pop;
   logic          push;
   logic [CW-1:0] occ;

   // Handshake decode and credit check; a pop in this cycle frees its slot
   // immediately so a full queue resumes issuing without a bubble.
   always_comb begin
      head_vld = (count != '0);
      pop      = head_vld && bus.inst_ready && !bus.redirect_valid;
      push     = vld_p1 && !bus.redirect_valid;
      occ      = CW'(count) + CW'(vld_p1) - CW'(pop);
      issue    = !rst && !bus.redirect_valid && (occ < DEPTH_C);
   end

   assign bus.inst_valid = head_vld;
   assign bus.inst_data  = data_mem[rd_ptr];
   assign bus.inst_pc    = pc_mem[rd_ptr];
   assign bus.isram_en   = issue;
   assign bus.isram_addr = fetch_pc[15:2];

   // Control state: fetch pointer, in-flight flag, FIFO pointers and count.
   // Reset and redirect both empty the queue and kill the in-flight read.
   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc <= align_word(RESET_PC);
         vld_p1   <= 1'b0;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
      end else if (bus.redirect_valid) begin
         fetch_pc <= align_word(bus.redirect_pc);
         vld_p1   <= 1'b0;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
      end else begin
         vld_p1 <= issue;
         if (issue) begin
            fetch_pc <= next_word(fetch_pc);
         end
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         count <= count + NW'(push) - NW'(pop);
      end
   end

   // Datapath: remember the issued address and capture the returning word.
   always_ff @(posedge clk) begin
      if (issue) begin
         pc_p1 <= fetch_pc;
      end
      if (push) begin
         data_mem[wr_ptr] <= bus.isram_dataout;
         pc_mem[wr_ptr]   <= pc_p1;
      end
   end

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue. The SRAM model returns 32'hA000_0000 plus
// the word address one cycle after each enabled read and 32'hDEAD_BEEF when
// not enabled. RESET_PC has its low bits set so the word alignment on reset
// is exercised; the expected first fetch address is still 0.
module tb_ifetch_queue;

   logic clk = 1'b0;
   logic rst;
   int   nchecks = 0;
   int   nerrors = 0;

   ifetch_queue_if bus();

   ifetch_queue #(
      .DEPTH(4),
      .RESET_PC(32'h0000_0003)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   // Instruction SRAM model with one-cycle read latency
   always @(posedge clk) begin
      if (bus.isram_en)
         bus.isram_dataout <= 32'hA000_0000 + {18'h0, bus.isram_addr};
      else
         bus.isram_dataout <= 32'hDEAD_BEEF;
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   // Leaves the bench in cycle 0: reset applied, rst low, outputs settling.
   task automatic do_reset();
      rst = 1'b1;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc = 32'h0;
      bus.inst_ready = 1'b0;
      cyc();
      cyc();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc = 32'h0;
      bus.inst_ready = 1'b1;
      cyc();
      cyc();
      settle();
      nchecks++;
      if (bus.inst_valid !== 1'b0) begin
         nerrors++;
         $display("FAIL reset_inst_valid: got %b want 0", bus.inst_valid);
      end
      nchecks++;
      if (bus.isram_en !== 1'b0) begin
         nerrors++;
         $display("FAIL reset_isram_en: got %b want 0", bus.isram_en);
      end
      rst = 1'b0;
      settle();
      nchecks++;
      if (bus.isram_en !== 1'b1 || bus.isram_addr !== 14'h0) begin
         nerrors++;
         $display("FAIL reset_first_issue: got en=%b addr=%h want en=1 addr=0000", bus.isram_en, bus.isram_addr);
      end
      nchecks++;
      if (bus.inst_valid !== 1'b0) begin
         nerrors++;
         $display("FAIL reset_release_valid: got %b want 0", bus.inst_valid);
      end
   endtask

   task automatic test_stream();
      do_reset();
      bus.inst_ready = 1'b1;
      for (int c = 0; c < 22; c++) begin
         settle();
         nchecks++;
         if (bus.isram_en !== 1'b1 || bus.isram_addr !== 14'(c)) begin
            nerrors++;
            $display("FAIL stream_issue c=%0d: got en=%b addr=%h want en=1 addr=%h", c, bus.isram_en, bus.isram_addr, 14'(c));
         end
         nchecks++;
         if (c < 2) begin
            if (bus.inst_valid !== 1'b0) begin
               nerrors++;
               $display("FAIL stream_latency c=%0d: got valid=%b want 0", c, bus.inst_valid);
            end
         end else if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'((c - 2) * 4) ||
                      bus.inst_data !== 32'hA000_0000 + 32'(c - 2)) begin
            nerrors++;
            $display("FAIL stream_deliver c=%0d: got v=%b pc=%h d=%h want v=1 pc=%h d=%h", c, bus.inst_valid, bus.inst_pc, bus.inst_data, 32'((c - 2) * 4), 32'hA000_0000 + 32'(c - 2));
         end
         cyc();
      end
   endtask

   task automatic test_stall();
      do_reset();
      bus.inst_ready = 1'b0;
      for (int c = 0; c < 10; c++) begin
         settle();
         nchecks++;
         if (bus.isram_en !== (c < 4) || (c < 4 && bus.isram_addr !== 14'(c))) begin
            nerrors++;
            $display("FAIL stall_issue c=%0d: got en=%b addr=%h want en=%b addr=%h", c, bus.isram_en, bus.isram_addr, (c < 4), 14'(c));
         end
         cyc();
      end
      bus.inst_ready = 1'b1;
      for (int k = 0; k < 12; k++) begin
         settle();
         nchecks++;
         if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'(k * 4) ||
             bus.inst_data !== 32'hA000_0000 + 32'(k)) begin
            nerrors++;
            $display("FAIL stall_drain k=%0d: got v=%b pc=%h d=%h want v=1 pc=%h d=%h", k, bus.inst_valid, bus.inst_pc, bus.inst_data, 32'(k * 4), 32'hA000_0000 + 32'(k));
         end
         nchecks++;
         if (bus.isram_en !== 1'b1 || bus.isram_addr !== 14'(4 + k)) begin
            nerrors++;
            $display("FAIL stall_resume k=%0d: got en=%b addr=%h want en=1 addr=%h", k, bus.isram_en, bus.isram_addr, 14'(4 + k));
         end
         cyc();
      end
   endtask

   task automatic test_redirect();
      do_reset();
      bus.inst_ready = 1'b0;
      for (int c = 0; c < 4; c++) cyc();
      // cycle 4: three entries buffered, read of word 3 in flight
      bus.redirect_valid = 1'b1;
      bus.redirect_pc = 32'h0000_0103;
      settle();
      nchecks++;
      if (bus.isram_en !== 1'b0) begin
         nerrors++;
         $display("FAIL redir_no_issue: got en=%b want 0", bus.isram_en);
      end
      cyc();
      bus.redirect_valid = 1'b0;
      settle();
      nchecks++;
      if (bus.inst_valid !== 1'b0 || bus.isram_en !== 1'b1 || bus.isram_addr !== 14'h0040) begin
         nerrors++;
         $display("FAIL redir_next: got v=%b en=%b addr=%h want v=0 en=1 addr=0040", bus.inst_valid, bus.isram_en, bus.isram_addr);
      end
      bus.inst_ready = 1'b1;
      cyc();
      settle();
      nchecks++;
      if (bus.inst_valid !== 1'b0 || bus.isram_addr !== 14'h0041) begin
         nerrors++;
         $display("FAIL redir_stale: got v=%b pc=%h addr=%h want v=0 addr=0041", bus.inst_valid, bus.inst_pc, bus.isram_addr);
      end
      cyc();
      settle();
      nchecks++;
      if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h0000_0100 || bus.inst_data !== 32'hA000_0040) begin
         nerrors++;
         $display("FAIL redir_first: got v=%b pc=%h d=%h want v=1 pc=00000100 d=a0000040", bus.inst_valid, bus.inst_pc, bus.inst_data);
      end
      cyc();
      settle();
      nchecks++;
      if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h0000_0104 || bus.inst_data !== 32'hA000_0041) begin
         nerrors++;
         $display("FAIL redir_second: got v=%b pc=%h d=%h want v=1 pc=00000104 d=a0000041", bus.inst_valid, bus.inst_pc, bus.inst_data);
      end
   endtask

   task automatic test_redirect_pop();
      do_reset();
      bus.inst_ready = 1'b1;
      for (int c = 0; c < 3; c++) cyc();
      // cycle 3: head valid and accepted, but redirect wins
      bus.redirect_valid = 1'b1;
      bus.redirect_pc = 32'h0000_0080;
      settle();
      nchecks++;
      if (bus.inst_valid !== 1'b1 || bus.isram_en !== 1'b0) begin
         nerrors++;
         $display("FAIL rpop_cycle: got v=%b en=%b want v=1 en=0", bus.inst_valid, bus.isram_en);
      end
      cyc();
      bus.redirect_valid = 1'b0;
      settle();
      nchecks++;
      if (bus.inst_valid !== 1'b0 || bus.isram_addr !== 14'h0020) begin
         nerrors++;
         $display("FAIL rpop_empty: got v=%b addr=%h want v=0 addr=0020", bus.inst_valid, bus.isram_addr);
      end
      cyc();
      cyc();
      settle();
      nchecks++;
      if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h0000_0080) begin
         nerrors++;
         $display("FAIL rpop_first: got v=%b pc=%h want v=1 pc=00000080", bus.inst_valid, bus.inst_pc);
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      bus.inst_ready = 1'b1;
      for (int c = 0; c < 3; c++) cyc();
      bus.redirect_valid = 1'b1;
      bus.redirect_pc = 32'h0000_0200;
      settle();
      nchecks++;
      if (bus.isram_en !== 1'b0) begin
         nerrors++;
         $display("FAIL b2b_first: got en=%b want 0", bus.isram_en);
      end
      cyc();
      bus.redirect_pc = 32'h0000_0300;
      settle();
      nchecks++;
      if (bus.isram_en !== 1'b0) begin
         nerrors++;
         $display("FAIL b2b_second: got en=%b want 0", bus.isram_en);
      end
      cyc();
      bus.redirect_valid = 1'b0;
      settle();
      nchecks++;
      if (bus.isram_en !== 1'b1 || bus.isram_addr !== 14'h00C0 || bus.inst_valid !== 1'b0) begin
         nerrors++;
         $display("FAIL b2b_issue: got en=%b addr=%h v=%b want en=1 addr=00c0 v=0", bus.isram_en, bus.isram_addr, bus.inst_valid);
      end
      cyc();
      settle();
      nchecks++;
      if (bus.inst_valid !== 1'b0) begin
         nerrors++;
         $display("FAIL b2b_gap: got v=%b pc=%h want v=0", bus.inst_valid, bus.inst_pc);
      end
      cyc();
      settle();
      nchecks++;
      if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h0000_0300 || bus.inst_data !== 32'hA000_00C0) begin
         nerrors++;
         $display("FAIL b2b_deliver: got v=%b pc=%h d=%h want v=1 pc=00000300 d=a00000c0", bus.inst_valid, bus.inst_pc, bus.inst_data);
      end
      cyc();
      settle();
      nchecks++;
      if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h0000_0304) begin
         nerrors++;
         $display("FAIL b2b_next: got v=%b pc=%h want v=1 pc=00000304", bus.inst_valid, bus.inst_pc);
      end
   endtask

   task automatic test_wrap();
      do_reset();
      bus.inst_ready = 1'b1;
      bus.redirect_valid = 1'b1;
      bus.redirect_pc = 32'h0000_FFFC;
      cyc();
      bus.redirect_valid = 1'b0;
      settle();
      nchecks++;
      if (bus.isram_en !== 1'b1 || bus.isram_addr !== 14'h3FFF) begin
         nerrors++;
         $display("FAIL wrap_addr0: got en=%b addr=%h want en=1 addr=3fff", bus.isram_en, bus.isram_addr);
      end
      cyc();
      settle();
      nchecks++;
      if (bus.isram_en !== 1'b1 || bus.isram_addr !== 14'h0000) begin
         nerrors++;
         $display("FAIL wrap_addr1: got en=%b addr=%h want en=1 addr=0000", bus.isram_en, bus.isram_addr);
      end
      cyc();
      settle();
      nchecks++;
      if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h0000_FFFC || bus.inst_data !== 32'hA000_3FFF) begin
         nerrors++;
         $display("FAIL wrap_pc0: got v=%b pc=%h d=%h want v=1 pc=0000fffc d=a0003fff", bus.inst_valid, bus.inst_pc, bus.inst_data);
      end
      cyc();
      settle();
      nchecks++;
      if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h0001_0000 || bus.inst_data !== 32'hA000_0000) begin
         nerrors++;
         $display("FAIL wrap_pc1: got v=%b pc=%h d=%h want v=1 pc=00010000 d=a0000000", bus.inst_valid, bus.inst_pc, bus.inst_data);
      end
   endtask

   task automatic test_reset_midway();
      do_reset();
      bus.inst_ready = 1'b0;
      for (int c = 0; c < 4; c++) cyc();
      // cycle 4: credits exhausted, read of word 3 in flight
      rst = 1'b1;
      settle();
      nchecks++;
      if (bus.isram_en !== 1'b0) begin
         nerrors++;
         $display("FAIL mid_rst_en: got en=%b want 0", bus.isram_en);
      end
      cyc();
      rst = 1'b0;
      settle();
      nchecks++;
      if (bus.inst_valid !== 1'b0 || bus.isram_en !== 1'b1 || bus.isram_addr !== 14'h0000) begin
         nerrors++;
         $display("FAIL mid_rst_restart: got v=%b en=%b addr=%h want v=0 en=1 addr=0000", bus.inst_valid, bus.isram_en, bus.isram_addr);
      end
      bus.inst_ready = 1'b1;
      cyc();
      settle();
      nchecks++;
      if (bus.inst_valid !== 1'b0) begin
         nerrors++;
         $display("FAIL mid_rst_stale: got v=%b pc=%h d=%h want v=0", bus.inst_valid, bus.inst_pc, bus.inst_data);
      end
      cyc();
      settle();
      nchecks++;
      if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h0 || bus.inst_data !== 32'hA000_0000) begin
         nerrors++;
         $display("FAIL mid_rst_first: got v=%b pc=%h d=%h want v=1 pc=00000000 d=a0000000", bus.inst_valid, bus.inst_pc, bus.inst_data);
      end
      cyc();
      settle();
      nchecks++;
      if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h4 || bus.inst_data !== 32'hA000_0001) begin
         nerrors++;
         $display("FAIL mid_rst_second: got v=%b pc=%h d=%h want v=1 pc=00000004 d=a0000001", bus.inst_valid, bus.inst_pc, bus.inst_data);
      end
   endtask

   initial begin
      rst = 1'b1;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc = 32'h0;
      bus.inst_ready = 1'b0;
      #1;
      test_reset();
      test_stream();
      test_stall();
      test_redirect();
      test_redirect_pop();
      test_back_to_back();
      test_wrap();
      test_reset_midway();
      $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
      $finish;
   end

endmodule
